// File: rtl/cpt_prescaler.sv
// Programmable prescaler: divides enable-qualified cycles by div and emits a
// one-cycle tick per period, either continuously or once (oneshot mode).
module cpt_prescaler #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            enable,
  input  logic            oneshot,
  input  logic [SIZE-1:0] div,
  output logic            tick,
  output logic            busy,
  output logic [SIZE-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [SIZE-1:0] r_cnt, w_cnt_nxt;
  logic [SIZE-1:0] r_div, w_div_nxt;
  logic            r_mode, w_mode_nxt;
  logic            r_tick, w_tick_nxt;
  logic [SIZE-1:0] w_term;

  // A ratio of zero behaves like one, so the terminal never wraps to all-ones.
  assign w_term = (r_div == '0) ? '0 : r_div - SIZE'(1);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_mode_nxt  = r_mode;
    w_tick_nxt  = 1'b0;

    if (stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (start) begin
      // A restart discards any pending terminal; the new ratio applies at once.
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_div_nxt   = div;
      w_mode_nxt  = oneshot;
    end else begin
      case (r_state)
        S_RUN: begin
          if (enable) begin
            if (r_cnt == w_term) begin
              w_cnt_nxt  = '0;
              w_tick_nxt = 1'b1;
              if (r_mode) w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt = r_cnt + SIZE'(1);
            end
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_mode  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_mode  <= w_mode_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign tick = r_tick;
  assign busy = (r_state == S_RUN);
  assign cnt  = r_cnt;

endmodule
